// File: rtl/tdc_interval_calc_pkg.sv
// Shared types and constants for the TDC interval calculator.
`ifndef NUM_DECODE
`define NUM_DECODE 6
`endif

package tdc_interval_calc_pkg;

   // Width of a fine-bin code produced by the edge-detector decoders.
   localparam int unsigned BIN_W = `NUM_DECODE;
   localparam int unsigned ERR_W = 2;

   typedef logic [ERR_W-1:0] err_t;

   localparam err_t ERR_OK     = 2'b00;
   localparam err_t ERR_OVF    = 2'b01;
   localparam err_t ERR_TMO    = 2'b10;
   localparam err_t ERR_NOEDGE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COUNT    = 3'd1,
      ST_WAIT_DEC = 3'd2,
      ST_CALC     = 3'd3,
      ST_OUT      = 3'd4
   } state_t;

endpackage

// File: rtl/tdc_interval_calc_if.sv
// Result channel of the interval calculator: valid/ready with data and error code.
interface tdc_interval_calc_if #(
   parameter int unsigned RESULT_W = 24
);
   import tdc_interval_calc_pkg::*;

   logic                result_valid;
   logic                result_ready;
   logic [RESULT_W-1:0] result_data;
   err_t                result_err;

   modport master (
      output result_valid,
      output result_data,
      output result_err,
      input  result_ready
   );

   modport slave (
      input  result_valid,
      input  result_data,
      input  result_err,
      output result_ready
   );
endinterface

// File: rtl/tdc_coarse_counter.sv
// Coarse clock-cycle counter that sticks at its maximum value.
module tdc_coarse_counter #(
   parameter int unsigned COARSE_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                enable,
   output logic [COARSE_W-1:0] count,
   output logic                sat
);

   localparam logic [COARSE_W-1:0] CNT_MAX = '1;

   // Count up while enabled; sat rises together with count reaching all-ones.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (enable && !sat) begin
         count <= count + COARSE_W'(1);
         sat   <= (count == CNT_MAX - COARSE_W'(1));
      end
   end

endmodule

// File: rtl/tdc_interval_calc.sv
// Measures start-to-stop interval: coarse cycles times taps-per-clock plus fine-bin correction.
module tdc_interval_calc
   import tdc_interval_calc_pkg::*;
#(
   parameter int unsigned COARSE_W    = 16,
   parameter int unsigned CLK_TAPS    = 36,
   parameter int unsigned RESULT_W    = 24,
   parameter int unsigned DEC_TIMEOUT = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_hit,
   input  logic             stop_hit,
   output logic             start_go,
   output logic             stop_go,
   input  logic             start_finished,
   input  logic [BIN_W-1:0] start_bin,
   input  logic             stop_finished,
   input  logic [BIN_W-1:0] stop_bin,
   tdc_interval_calc_if.master res,
   output logic [7:0]       drop_cnt
);

   localparam int unsigned       TMO_W   = $clog2(DEC_TIMEOUT + 2);
   localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(DEC_TIMEOUT);

   state_t              state;
   logic [COARSE_W-1:0] coarse;
   logic                coarse_sat;
   logic [BIN_W-1:0]    start_bin_q;
   logic [BIN_W-1:0]    stop_bin_q;
   logic                start_got;
   logic                stop_got;
   logic [TMO_W-1:0]    tmo_cnt;
   err_t                err_q;

   logic                start_cap_c;
   logic                stop_cap_c;
   logic                both_c;
   logic                cnt_clear_c;
   logic                cnt_en_c;
   logic [RESULT_W-1:0] interval_c;

   // The start decoder may finish while stop is still being counted, so accept it in COUNT too.
   assign start_cap_c = start_finished && !start_got &&
                        ((state == ST_COUNT) || (state == ST_WAIT_DEC));
   assign stop_cap_c  = stop_finished && !stop_got && (state == ST_WAIT_DEC);
   assign both_c      = (start_got || start_cap_c) && (stop_got || stop_cap_c);
   assign cnt_clear_c = (state == ST_IDLE) && start_hit;
   assign cnt_en_c    = (state == ST_COUNT);

   // Constant multiply; modular RESULT_W arithmetic gives the two's-complement interval.
   assign interval_c = RESULT_W'(coarse) * RESULT_W'(CLK_TAPS)
                     + RESULT_W'(start_bin_q) - RESULT_W'(stop_bin_q);

   tdc_coarse_counter #(
      .COARSE_W (COARSE_W)
   ) u_coarse (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear_c),
      .enable (cnt_en_c),
      .count  (coarse),
      .sat    (coarse_sat)
   );

   // Measurement sequencer: go pulses, bin capture, decoder timeout, result hand-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         start_go         <= 1'b0;
         stop_go          <= 1'b0;
         start_bin_q      <= '0;
         stop_bin_q       <= '0;
         start_got        <= 1'b0;
         stop_got         <= 1'b0;
         tmo_cnt          <= '0;
         err_q            <= ERR_OK;
         res.result_valid <= 1'b0;
         res.result_data  <= '0;
         res.result_err   <= ERR_OK;
      end else begin
         start_go <= 1'b0;
         stop_go  <= 1'b0;

         if (start_cap_c) begin
            start_bin_q <= start_bin;
            start_got   <= 1'b1;
         end
         if (stop_cap_c) begin
            stop_bin_q <= stop_bin;
            stop_got   <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start_hit) begin
                  start_go    <= 1'b1;
                  start_got   <= 1'b0;
                  stop_got    <= 1'b0;
                  start_bin_q <= '0;
                  stop_bin_q  <= '0;
                  err_q       <= ERR_OK;
                  tmo_cnt     <= '0;
                  if (stop_hit) begin
                     stop_go <= 1'b1;
                     state   <= ST_WAIT_DEC;
                  end else begin
                     state   <= ST_COUNT;
                  end
               end
            end

            ST_COUNT: begin
               // A saturated counter cannot represent a later stop: flag it and close anyway.
               if (coarse_sat) begin
                  err_q   <= ERR_OVF;
                  stop_go <= 1'b1;
                  tmo_cnt <= '0;
                  state   <= ST_WAIT_DEC;
               end else if (stop_hit) begin
                  stop_go <= 1'b1;
                  tmo_cnt <= '0;
                  state   <= ST_WAIT_DEC;
               end
            end

            ST_WAIT_DEC: begin
               if (both_c) begin
                  state <= ST_CALC;
               end else if (tmo_cnt == TMO_MAX) begin
                  if (err_q == ERR_OK) begin
                     err_q <= ERR_TMO;
                  end
                  state <= ST_CALC;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end

            ST_CALC: begin
               res.result_data  <= interval_c;
               res.result_valid <= 1'b1;
               if ((err_q == ERR_OK) && ((start_bin_q == '0) || (stop_bin_q == '0))) begin
                  res.result_err <= ERR_NOEDGE;
               end else begin
                  res.result_err <= err_q;
               end
               state <= ST_OUT;
            end

            ST_OUT: begin
               if (res.result_ready) begin
                  res.result_valid <= 1'b0;
                  state            <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   // Count start hits that arrive while a measurement is already in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (start_hit && (state != ST_IDLE) && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_tdc_interval_calc.sv
// Self-checking bench for tdc_interval_calc with a schedule-level reference model.
module tb_tdc_interval_calc;
   import tdc_interval_calc_pkg::*;

   localparam int unsigned RESULT_W    = 24;
   localparam int unsigned CLK_TAPS    = 36;
   localparam int unsigned DEC_TIMEOUT = 7;
   localparam int unsigned COARSE_W0   = 16;
   localparam int unsigned COARSE_W1   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             sel;
   logic             hit_start, hit_stop, fin_s, fin_p, rdy;
   logic [BIN_W-1:0] bin_s, bin_p;

   logic sh0, sp0, fs0, fp0, sg0, pg0;
   logic sh1, sp1, fs1, fp1, sg1, pg1;
   logic [7:0] drop0, drop1;

   logic                o_sg, o_pg, o_valid;
   logic [RESULT_W-1:0] o_data;
   logic [1:0]          o_err;
   logic [7:0]          o_drop;

   tdc_interval_calc_if #(.RESULT_W(RESULT_W)) res0 ();
   tdc_interval_calc_if #(.RESULT_W(RESULT_W)) res1 ();

   assign sh0 = hit_start & ~sel;
   assign sp0 = hit_stop  & ~sel;
   assign fs0 = fin_s     & ~sel;
   assign fp0 = fin_p     & ~sel;
   assign sh1 = hit_start & sel;
   assign sp1 = hit_stop  & sel;
   assign fs1 = fin_s     & sel;
   assign fp1 = fin_p     & sel;
   assign res0.result_ready = rdy & ~sel;
   assign res1.result_ready = rdy & sel;

   assign o_sg    = sel ? sg1 : sg0;
   assign o_pg    = sel ? pg1 : pg0;
   assign o_valid = sel ? res1.result_valid : res0.result_valid;
   assign o_data  = sel ? res1.result_data  : res0.result_data;
   assign o_err   = sel ? res1.result_err   : res0.result_err;
   assign o_drop  = sel ? drop1 : drop0;

   tdc_interval_calc #(
      .COARSE_W(COARSE_W0), .CLK_TAPS(CLK_TAPS), .RESULT_W(RESULT_W), .DEC_TIMEOUT(DEC_TIMEOUT)
   ) dut0 (
      .clk(clk), .rst(rst), .start_hit(sh0), .stop_hit(sp0),
      .start_go(sg0), .stop_go(pg0),
      .start_finished(fs0), .start_bin(bin_s),
      .stop_finished(fp0), .stop_bin(bin_p),
      .res(res0), .drop_cnt(drop0)
   );

   tdc_interval_calc #(
      .COARSE_W(COARSE_W1), .CLK_TAPS(CLK_TAPS), .RESULT_W(RESULT_W), .DEC_TIMEOUT(DEC_TIMEOUT)
   ) dut1 (
      .clk(clk), .rst(rst), .start_hit(sh1), .stop_hit(sp1),
      .start_go(sg1), .stop_go(pg1),
      .start_finished(fs1), .start_bin(bin_s),
      .stop_finished(fp1), .stop_bin(bin_p),
      .res(res1), .drop_cnt(drop1)
   );

   int errors = 0;
   int checks = 0;
   int drop_exp [2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      hit_start = 1'b0;
      hit_stop  = 1'b0;
      fin_s     = 1'b0;
      fin_p     = 1'b0;
      rdy       = 1'b0;
   endtask

   // One measurement. Step t is 1 time unit after clock edge t; inputs set at step t are seen at edge t+1.
   // k: stop_hit step (-1 none); ds/dp: decoder delay after its go (0 = never finishes).
   task automatic run_txn(input string name, input int k, input int sb, input int pb,
                          input int ds, input int dp, input int rdy_wait, input int extra);
      int  max_c, coarse, g, fs, fp, v, t_end, sbin, pbin, tmp;
      bit  ovf, got_s, got_p;
      logic [1:0]  err_e;
      logic [31:0] data_e;

      max_c = (1 << (sel ? COARSE_W1 : COARSE_W0)) - 1;
      if (k < 0 || k > max_c) begin
         ovf    = 1'b1;
         coarse = max_c;
         g      = max_c + 2;
      end else begin
         ovf    = 1'b0;
         coarse = k;
         g      = k + 1;
      end
      fs    = (ds > 0) ? 1 + ds : -1;
      fp    = (dp > 0) ? g + dp : -1;
      got_s = (fs > 0) && (fs <= g + int'(DEC_TIMEOUT));
      got_p = (fp > 0) && (fp <= g + int'(DEC_TIMEOUT));
      v     = (got_s && got_p) ? ((fs > fp ? fs : fp) + 2) : (g + int'(DEC_TIMEOUT) + 2);
      sbin  = got_s ? sb : 0;
      pbin  = got_p ? pb : 0;
      if (ovf)                        err_e = ERR_OVF;
      else if (!(got_s && got_p))     err_e = ERR_TMO;
      else if (sbin == 0 || pbin == 0) err_e = ERR_NOEDGE;
      else                            err_e = ERR_OK;
      tmp    = coarse * int'(CLK_TAPS) + sbin - pbin;
      data_e = 32'(tmp) & 32'h00FF_FFFF;
      t_end  = v + rdy_wait + 1;
      drop_exp[sel] = drop_exp[sel] + extra;
      if (drop_exp[sel] > 255) drop_exp[sel] = 255;

      for (int t = 0; t <= t_end; t++) begin
         check_eq({name, " start_go"}, 32'(o_sg), 32'(t == 1));
         check_eq({name, " stop_go"},  32'(o_pg), 32'(t == g));
         check_eq({name, " valid"},    32'(o_valid), 32'((t >= v) && (t <= v + rdy_wait)));
         if (t >= v && t <= v + rdy_wait) begin
            check_eq({name, " data"}, 32'(o_data), data_e);
            check_eq({name, " err"},  32'(o_err),  32'(err_e));
         end
         if (t == t_end) begin
            check_eq({name, " drop_cnt"}, 32'(o_drop), 32'(drop_exp[sel]));
            break;
         end
         hit_start = (t == 0) || ((t > v) && (t <= v + extra));
         hit_stop  = (t == k);
         fin_s     = (t == fs);
         fin_p     = (t == fp);
         bin_s     = (fs > 0 && t >= fs) ? BIN_W'(sb) : BIN_W'($urandom);
         bin_p     = (fp > 0 && t >= fp) ? BIN_W'(pb) : BIN_W'($urandom);
         rdy       = (t >= v + rdy_wait);
         step();
      end
      drive_idle();
   endtask

   initial begin
      int k, sb, pb, ds, dp, rw, ex;
      sel   = 1'b0;
      rst   = 1'b1;
      bin_s = '0;
      bin_p = '0;
      drive_idle();
      drop_exp[0] = 0;
      drop_exp[1] = 0;
      repeat (3) step();
      rst = 1'b0;
      check_eq("reset valid",    32'(o_valid), 32'(0));
      check_eq("reset data",     32'(o_data),  32'(0));
      check_eq("reset err",      32'(o_err),   32'(0));
      check_eq("reset start_go", 32'(o_sg),    32'(0));
      check_eq("reset stop_go",  32'(o_pg),    32'(0));
      check_eq("reset drop_cnt", 32'(o_drop),  32'(0));
      step();

      // Lone stop_hit in IDLE must not start anything.
      hit_stop = 1'b1;
      step();
      hit_stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_eq("stop_alone go",    32'(o_sg | o_pg), 32'(0));
         check_eq("stop_alone valid", 32'(o_valid),     32'(0));
         step();
      end

      run_txn("basic",        5, 20,  8, 3, 2, 0, 0);
      run_txn("same_hit",     0,  5,  9, 2, 2, 1, 0);
      run_txn("fin_same",     3, 10,  3, 4, 1, 0, 0);
      run_txn("stop_first",   3, 10,  3, 6, 1, 0, 0);
      run_txn("tmo_stop",     4, 13,  6, 2, 0, 0, 0);
      run_txn("tmo_late",     2, 13,  6, 2, 9, 0, 0);
      run_txn("noedge",       2,  0,  7, 2, 3, 0, 0);
      run_txn("hold",         6, 17, 30, 2, 3, 20, 3);

      // Reset while waiting for decoders; finished pulses around it are discarded.
      hit_start = 1'b1;
      step();
      hit_start = 1'b0;
      step();
      step();
      hit_stop = 1'b1;
      step();
      hit_stop = 1'b0;
      check_eq("rst_mid stop_go", 32'(o_pg), 32'(1));
      step();
      rst   = 1'b1;
      fin_s = 1'b1;
      bin_s = BIN_W'(9);
      step();
      check_eq("rst_mid valid",    32'(o_valid),     32'(0));
      check_eq("rst_mid data",     32'(o_data),      32'(0));
      check_eq("rst_mid err",      32'(o_err),       32'(0));
      check_eq("rst_mid go",       32'(o_sg | o_pg), 32'(0));
      check_eq("rst_mid drop_cnt", 32'(o_drop),      32'(0));
      drop_exp[0] = 0;
      drop_exp[1] = 0;
      rst   = 1'b0;
      fin_s = 1'b1;
      fin_p = 1'b1;
      bin_p = BIN_W'(4);
      step();
      fin_s = 1'b0;
      fin_p = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_eq("rst_late valid", 32'(o_valid),     32'(0));
         check_eq("rst_late go",    32'(o_sg | o_pg), 32'(0));
         step();
      end
      run_txn("after_rst", 7, 11, 2, 1, 1, 0, 0);

      // Narrow coarse counter instance for overflow behaviour.
      sel = 1'b1;
      step();
      run_txn("c4_max",      15,  6,  6, 2, 2, 0, 0);
      run_txn("ovf_nostop",  -1, 11,  4, 3, 2, 1, 0);
      run_txn("ovf_edge",    16, 12,  5, 2, 4, 0, 0);
      sel = 1'b0;
      step();

      for (int n = 0; n < 30; n++) begin
         k  = int'($urandom_range(0, 40));
         sb = int'($urandom_range(0, 35));
         pb = int'($urandom_range(0, 35));
         if ($urandom_range(0, 7) == 0) sb = 0;
         if ($urandom_range(0, 7) == 0) pb = 0;
         ds = int'($urandom_range(0, 10));
         dp = int'($urandom_range(0, 10));
         rw = int'($urandom_range(0, 4));
         ex = (rw > 0) ? int'($urandom_range(0, rw)) : 0;
         run_txn($sformatf("rnd%0d", n), k, sb, pb, ds, dp, rw, ex);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/tdc_interval_calc.md
Name: tdc_interval_calc

Overview:
- Sits directly downstream of the start and stop edge-detector decoders in the TDC datapath.
- Counts coarse clock cycles between the synchronised start and stop hits.
- Issues the one-cycle go pulses to both decoders, then captures their fine bins on their finished pulses.
- Combines coarse and fine values into one signed interval in tap units, presented on a valid/ready output with error code.

Parameters:
- COARSE_W, 16: coarse cycle counter width.
- CLK_TAPS, 36: taps per clock period; integer calibration constant.
- RESULT_W, 24: interval result width, two's complement.
- DEC_TIMEOUT, 7: max cycles to wait for both finished pulses after go.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_hit  in  1  one-cycle pulse: start event sampled into delay line.
- stop_hit  in  1  one-cycle pulse: stop event sampled into delay line.
- start_go  out  1  one-cycle go to start decoder.
- stop_go  out  1  one-cycle go to stop decoder.
- start_finished  in  1  start decoder finished pulse.
- start_bin  in  `NUM_DECODE  start decoder output, valid from finished cycle onward.
- stop_finished  in  1  stop decoder finished pulse.
- stop_bin  in  `NUM_DECODE  stop decoder output.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- result_data  out  RESULT_W  signed interval in taps.
- result_err  out  2  00 ok, 01 coarse overflow, 10 decoder timeout, 11 no edge (bin==0).
- drop_cnt  out  8  saturating count of start_hit ignored while busy.

Behaviour:
- Reset (sync, rst high at posedge):
  - State IDLE.
  - All outputs 0; coarse, captured bins, timeout counter and drop_cnt cleared.
  - In-flight finished pulses are discarded.
- FSM states: IDLE, COUNT, WAIT_DEC, CALC, OUT.
- IDLE:
  - start_hit: start_go=1 in the next cycle, coarse cleared to 0, go to COUNT.
  - stop_hit alone is ignored.
  - start_hit and stop_hit in the same cycle: coarse=0; start_go and stop_go both pulse next cycle; go directly to WAIT_DEC.
- COUNT:
  - coarse increments every cycle.
  - Value captured is k when stop_hit arrives k cycles after start_hit.
  - On stop_hit: stop_go pulses next cycle; go to WAIT_DEC.
  - If coarse reaches 2^COARSE_W-1 before stop_hit: latch err=01, pulse stop_go anyway, go to WAIT_DEC.
- WAIT_DEC:
  - Capture start_bin on start_finished and stop_bin on stop_finished.
  - The two pulses may arrive in either order or in the same cycle.
  - A second finished pulse from the same decoder is ignored.
  - Timeout counter starts at the last go and increments each cycle.
  - Both captured: go to CALC.
  - Counter reaches DEC_TIMEOUT first: err=10 (unless 01 already latched), go to CALC.
- CALC (1 cycle):
  - result = coarse*CLK_TAPS + start_bin - stop_bin, zero-extended operands, signed RESULT_W arithmetic; multiplier is a constant.
  - If err is still 00 and either captured bin==0: err=11.
  - Go to OUT.
- OUT:
  - result_valid=1; result_data and result_err held stable until result_valid & result_ready.
  - Return to IDLE on the cycle after the transfer.
- Busy handling: start_hit in any state except IDLE increments drop_cnt (saturating at 255) and is otherwise ignored. stop_hit outside IDLE/COUNT is ignored.
- Latencies:
  - Go outputs are exactly one cycle wide.
  - start_go is exactly one cycle after start_hit.
  - result_valid asserts exactly 2 cycles after the later finished pulse.
- Mid-operation reset behaves identically to power-on reset.

Decomposition:
- Shared package: error code constants (ERR_OK, ERR_OVF, ERR_TMO, ERR_NOEDGE) and FSM state encodings.
- NUM_DECODE comes from the existing shared defines.
- Sub-module tdc_coarse_counter: clear, enable, saturation flag, COARSE_W output.
- FSM, capture and arithmetic stay in the top.

Test Plan:
- CLK_TAPS=36; start_hit at cycle 10, stop_hit at cycle 15; bins start=20, stop=8 -> start_go at 11, stop_go at 16, result_data=192, err=00.
- start_hit and stop_hit same cycle; start_bin=5, stop_bin=9 -> both go same cycle, result_data=-4 (0xFFFFFC), err=00.
- Both finished pulses same cycle, then stop-before-start order -> identical results; valid 2 cycles after last finished.
- COARSE_W=4; no stop_hit -> err=01 after coarse hits 15, stop_go pulses, result still produced.
- Suppress stop_finished -> err=10 after DEC_TIMEOUT cycles; separately start_bin=0 -> err=11.
- result_ready low 20 cycles with 3 extra start_hits -> data/err held, drop_cnt=3, IDLE after ready; rst asserted in WAIT_DEC -> outputs 0, late finished ignored.
